edge_detector_mac: RTL and testbench

Multi-mode, parametrised 3×3 gradient engine. It is the sequential successor to the fixed Sobel coefficient table. The block accepts one 3×3 pixel window as a 9-beat valid/ready stream and accumulates Gx and Gy with one multiply-accumulate per beat. It then presents signed gradients and a saturated magnitude on a registered valid/ready output. It sits between the window-fetch logic and the Avalon-MM result writer.

---
 rtl/edge_detector_pkg.sv | 56 +++++
 rtl/edge_detector_coef_rom.sv | 40 ++++
 rtl/edge_detector_mac.sv | 183 ++++++++++++++++++
 tb/tb_edge_detector_mac.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detector_pkg.sv
// edge_detector_pkg
// Shared definitions for the 3x3 gradient engine:
//   - kernel select encodings (mode 3 is reserved and decodes as Sobel)
//   - coefficient width and the nine-entry Kx/Ky tables for each kernel,
//     stored in row-major beat order (entry k = row*3 + col)
//   - the engine state type
package edge_detector_pkg;

  localparam int COEF_W = 5;

  localparam logic [1:0] MODE_SOBEL   = 2'd0;
  localparam logic [1:0] MODE_PREWITT = 2'd1;
  localparam logic [1:0] MODE_SCHARR  = 2'd2;

  typedef logic signed [COEF_W-1:0] coef_t;

  // ACCUM collects the nine beats of a window, OUT presents the result.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  localparam coef_t SOBEL_KX [9] = '{
    -5'sd1, 5'sd0, 5'sd1,
    -5'sd2, 5'sd0, 5'sd2,
    -5'sd1, 5'sd0, 5'sd1
  };
  localparam coef_t SOBEL_KY [9] = '{
     5'sd1,  5'sd2,  5'sd1,
     5'sd0,  5'sd0,  5'sd0,
    -5'sd1, -5'sd2, -5'sd1
  };

  localparam coef_t PREWITT_KX [9] = '{
    -5'sd1, 5'sd0, 5'sd1,
    -5'sd1, 5'sd0, 5'sd1,
    -5'sd1, 5'sd0, 5'sd1
  };
  localparam coef_t PREWITT_KY [9] = '{
     5'sd1,  5'sd1,  5'sd1,
     5'sd0,  5'sd0,  5'sd0,
    -5'sd1, -5'sd1, -5'sd1
  };

  localparam coef_t SCHARR_KX [9] = '{
     -5'sd3, 5'sd0,  5'sd3,
    -5'sd10, 5'sd0, 5'sd10,
     -5'sd3, 5'sd0,  5'sd3
  };
  localparam coef_t SCHARR_KY [9] = '{
     5'sd3,  5'sd10,  5'sd3,
     5'sd0,   5'sd0,  5'sd0,
    -5'sd3, -5'sd10, -5'sd3
  };

endpackage

// File: rtl/edge_detector_coef_rom.sv
// edge_detector_coef_rom
// Combinational coefficient lookup for the gradient engine.
// Ports:
//   mode  in  2       kernel select (0 Sobel, 1 Prewitt, 2 Scharr, 3 -> Sobel)
//   tap   in  4       beat index within the window, 0..8
//   kx    out COEF_W  signed horizontal-gradient coefficient
//   ky    out COEF_W  signed vertical-gradient coefficient
module edge_detector_coef_rom
  import edge_detector_pkg::*;
(
  input  logic [1:0]               mode,
  input  logic [3:0]               tap,
  output logic signed [COEF_W-1:0] kx,
  output logic signed [COEF_W-1:0] ky
);

  // Taps beyond 8 never occur in normal operation; they read as zero so
  // the lookup can never index outside the nine-entry tables.
  always_comb begin
    kx = '0;
    ky = '0;
    if (tap <= 4'd8) begin
      case (mode)
        MODE_PREWITT: begin
          kx = PREWITT_KX[tap];
          ky = PREWITT_KY[tap];
        end
        MODE_SCHARR: begin
          kx = SCHARR_KX[tap];
          ky = SCHARR_KY[tap];
        end
        default: begin
          kx = SOBEL_KX[tap];
          ky = SOBEL_KY[tap];
        end
      endcase
    end
  end

endmodule

// File: rtl/edge_detector_mac.sv
// edge_detector_mac
// Sequential 3x3 gradient engine. A window arrives as nine row-major pixel
// beats on a valid/ready stream; each beat performs one multiply-accumulate
// into Gx and Gy. After the ninth beat the signed gradients and a shifted,
// saturated magnitude are registered and offered on a valid/ready output.
// Ports:
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      asynchronous active-high reset
//   flush_i      in   1      synchronous discard of partial window / pending result
//   mode_i       in   2      kernel select, sampled on beat 0 only
//   pix_valid_i  in   1      pixel beat valid
//   pix_i        in   PIX_W  unsigned pixel
//   pix_ready_o  out  1      engine accepts a beat (high in ACCUM)
//   out_valid_o  out  1      result valid (high in OUT)
//   out_ready_i  in   1      downstream accepts the result
//   gx_o         out  ACC_W  signed horizontal gradient
//   gy_o         out  ACC_W  signed vertical gradient
//   mag_o        out  PIX_W  min((|gx|+|gy|) >> SHIFT, all-ones)
module edge_detector_mac
  import edge_detector_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ACC_W = PIX_W + 6,
  parameter int SHIFT = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [1:0]              mode_i,
  input  logic                    pix_valid_i,
  input  logic [PIX_W-1:0]        pix_i,
  output logic                    pix_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [ACC_W-1:0] gx_o,
  output logic signed [ACC_W-1:0] gy_o,
  output logic [PIX_W-1:0]        mag_o
);

  localparam logic [3:0]   LAST_TAP = 4'd8;
  localparam logic [ACC_W:0] ONE    = {{ACC_W{1'b0}}, 1'b1};

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              tap_q;
  logic [1:0]              mode_q;
  logic [1:0]              rom_mode;
  logic signed [COEF_W-1:0] kx;
  logic signed [COEF_W-1:0] ky;

  logic signed [ACC_W-1:0] acc_gx_q;
  logic signed [ACC_W-1:0] acc_gy_q;
  logic signed [ACC_W-1:0] kx_ext;
  logic signed [ACC_W-1:0] ky_ext;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] prod_gx;
  logic signed [ACC_W-1:0] prod_gy;
  logic signed [ACC_W-1:0] sum_gx;
  logic signed [ACC_W-1:0] sum_gy;

  logic                    beat;
  logic                    last_beat;
  logic [ACC_W:0]          abs_gx;
  logic [ACC_W:0]          abs_gy;
  logic [ACC_W:0]          mag_sum;
  logic [ACC_W:0]          mag_shift;
  logic [PIX_W-1:0]        mag_d;

  // Magnitude of a signed accumulator, one bit wider so the most negative
  // value still has a representable absolute value.
  function automatic logic [ACC_W:0] abs_ext(input logic signed [ACC_W-1:0] v);
    logic [ACC_W:0] wide;
    wide = {v[ACC_W-1], v};
    return v[ACC_W-1] ? (~wide + ONE) : wide;
  endfunction

  // Handshake flags are pure functions of the state register, so there is
  // no combinational path from out_ready_i to pix_ready_o.
  assign pix_ready_o = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_OUT);

  // A flush in the same cycle swallows the beat.
  assign beat      = pix_valid_i && pix_ready_o && !flush_i;
  assign last_beat = beat && (tap_q == LAST_TAP);

  // On beat 0 the window's kernel has not been latched yet, so the lookup
  // uses the live mode; every later beat uses the latched copy.
  assign rom_mode = (tap_q == 4'd0) ? mode_i : mode_q;

  edge_detector_coef_rom u_coef_rom (
    .mode (rom_mode),
    .tap  (tap_q),
    .kx   (kx),
    .ky   (ky)
  );

  // Coefficients are sign-extended and pixels zero-extended to the
  // accumulator width; the worst-case product fits without overflow.
  assign kx_ext  = ACC_W'(kx);
  assign ky_ext  = ACC_W'(ky);
  assign pix_ext = ACC_W'(pix_i);
  assign prod_gx = kx_ext * pix_ext;
  assign prod_gy = ky_ext * pix_ext;

  // Beat 0 starts a fresh sum; later beats add onto the running total.
  assign sum_gx = (tap_q == 4'd0) ? prod_gx : (acc_gx_q + prod_gx);
  assign sum_gy = (tap_q == 4'd0) ? prod_gy : (acc_gy_q + prod_gy);

  // Magnitude is formed from the sums that include the current beat, so on
  // the final beat it can be registered alongside Gx and Gy in one edge.
  assign abs_gx    = abs_ext(sum_gx);
  assign abs_gy    = abs_ext(sum_gy);
  assign mag_sum   = abs_gx + abs_gy;
  assign mag_shift = mag_sum >> SHIFT;
  assign mag_d     = (|mag_shift[ACC_W:PIX_W]) ? '1 : mag_shift[PIX_W-1:0];

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Flush wins over both the final beat and the
  // downstream handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (last_beat) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (flush_i || out_ready_i) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Tap counter, kernel latch and accumulators. Only active in ACCUM;
  // in OUT the counter is already back at 0 and nothing accumulates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap_q    <= '0;
      mode_q   <= MODE_SOBEL;
      acc_gx_q <= '0;
      acc_gy_q <= '0;
    end else if (state_q == ST_ACCUM) begin
      if (flush_i) begin
        tap_q    <= '0;
        acc_gx_q <= '0;
        acc_gy_q <= '0;
      end else if (beat) begin
        if (tap_q == 4'd0) begin
          mode_q <= mode_i;
        end
        tap_q    <= last_beat ? 4'd0 : (tap_q + 4'd1);
        acc_gx_q <= sum_gx;
        acc_gy_q <= sum_gy;
      end
    end
  end

  // Result register: loaded only by the final beat of a window and held
  // unchanged while the result waits in OUT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gx_o  <= '0;
      gy_o  <= '0;
      mag_o <= '0;
    end else if (last_beat) begin
      gx_o  <= sum_gx;
      gy_o  <= sum_gy;
      mag_o <= mag_d;
    end
  end

endmodule

// File: tb/tb_edge_detector_mac.sv
// tb_edge_detector_mac
// Self-checking bench for edge_detector_mac (PIX_W=8, ACC_W=14, SHIFT=2).
// A window-level reference model derives every cycle's expected handshake
// and result from the kernel definitions; directed scenarios add literal
// expectations for the headline results.
module tb_edge_detector_mac;

  localparam int PIX_W = 8;
  localparam int ACC_W = 14;

  logic                    clk = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    flush_i = 1'b0;
  logic [1:0]              mode_i = 2'd0;
  logic                    pix_valid_i = 1'b0;
  logic [PIX_W-1:0]        pix_i = '0;
  logic                    pix_ready_o;
  logic                    out_valid_o;
  logic                    out_ready_i = 1'b0;
  logic signed [ACC_W-1:0] gx_o;
  logic signed [ACC_W-1:0] gy_o;
  logic [PIX_W-1:0]        mag_o;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state: beats collected so far and any pending result.
  int m_buf [9];
  int m_count = 0;
  int m_mode = 0;
  bit m_pending = 1'b0;
  int m_gx = 0;
  int m_gy = 0;
  int m_mag = 0;

  int edge_win   [9] = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
  int mirror_win [9] = '{255, 0, 0, 255, 0, 0, 255, 0, 0};
  int top_win    [9] = '{100, 100, 100, 0, 0, 0, 0, 0, 0};
  int ramp_win   [9] = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
  int corner_win [9] = '{200, 0, 0, 0, 0, 0, 0, 0, 0};
  int full_win   [9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};

  edge_detector_mac #(
    .PIX_W (PIX_W),
    .ACC_W (ACC_W),
    .SHIFT (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .mode_i      (mode_i),
    .pix_valid_i (pix_valid_i),
    .pix_i       (pix_i),
    .pix_ready_o (pix_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .gx_o        (gx_o),
    .gy_o        (gy_o),
    .mag_o       (mag_o)
  );

  always #5 clk = ~clk;

  // Outer-row/column weight of each kernel: centre entry vs corner entries.
  function automatic int weight(input int mode, input int i);
    if (i == 1) return (mode == 1) ? 1 : (mode == 2) ? 10 : 2;
    return (mode == 2) ? 3 : 1;
  endfunction

  // Kx is negative in the left column and positive in the right, Ky positive
  // in the top row and negative in the bottom, scaled by the kernel weights.
  function automatic void model_window(input int mode, input int px [9],
                                       output int gx, output int gy, output int mag);
    int ax;
    int ay;
    gx = 0;
    gy = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int p;
        p = px[r*3 + c];
        if (c == 0) gx -= weight(mode, r) * p;
        if (c == 2) gx += weight(mode, r) * p;
        if (r == 0) gy += weight(mode, c) * p;
        if (r == 2) gy -= weight(mode, c) * p;
      end
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = (ax + ay) >> 2;
    if (mag > 255) mag = 255;
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: update the model for what this edge must do, then
  // check the DUT a moment later.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_count   = 0;
      m_pending = 1'b0;
      #1;
      checkOutput("rst_ready", {31'b0, pix_ready_o}, 1);
      checkOutput("rst_valid", {31'b0, out_valid_o}, 0);
      checkOutput("rst_gx", gx_o, 0);
      checkOutput("rst_gy", gy_o, 0);
      checkOutput("rst_mag", {24'b0, mag_o}, 0);
    end else begin
      if (m_pending) begin
        if (flush_i || out_ready_i) m_pending = 1'b0;
      end else if (flush_i) begin
        m_count = 0;
      end else if (pix_valid_i) begin
        if (m_count == 0) m_mode = int'(mode_i);
        m_buf[m_count] = int'(pix_i);
        m_count++;
        if (m_count == 9) begin
          model_window(m_mode, m_buf, m_gx, m_gy, m_mag);
          m_pending = 1'b1;
          m_count   = 0;
        end
      end
      #1;
      checkOutput("ready", {31'b0, pix_ready_o}, m_pending ? 0 : 1);
      checkOutput("valid", {31'b0, out_valid_o}, m_pending ? 1 : 0);
      if (m_pending) begin
        checkOutput("gx", gx_o, m_gx);
        checkOutput("gy", gy_o, m_gy);
        checkOutput("mag", {24'b0, mag_o}, m_mag);
      end
    end
  end

  // Drives n beats of a window, one per cycle while the engine is ready.
  // Beats from alt_from onwards carry alt_mode instead of mode.
  task automatic applyStimulus(input int mode, input int alt_mode, input int alt_from,
                               input int px [9], input int n);
    for (int k = 0; k < n; k++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      out_ready_i = 1'b0;
      flush_i     = 1'b0;
      pix_valid_i = 1'b1;
      pix_i       = PIX_W'(px[k]);
      mode_i      = 2'((k >= alt_from) ? alt_mode : mode);
      while (!pix_ready_o && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) checkOutput("ready_timeout", {31'b0, pix_ready_o}, 1);
    end
  endtask

  // Called right after the final beat: the result must be valid one cycle
  // after the beat-8 handshake and match the hand-computed values.
  task automatic waitResult(input string name, input int gx, input int gy, input int mag);
    @(negedge clk);
    pix_valid_i = 1'b0;
    checkOutput({name, "_latency"}, {31'b0, out_valid_o}, 1);
    checkOutput({name, "_gx"}, gx_o, gx);
    checkOutput({name, "_gy"}, gy_o, gy);
    checkOutput({name, "_mag"}, {24'b0, mag_o}, mag);
  endtask

  task automatic releaseResult();
    @(negedge clk);
    out_ready_i = 1'b1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    pix_valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, out_valid_o}, 0);
    checkOutput("async_rst_gx", gx_o, 0);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    int gx;
    int gy;
    int mag;

    // Pin the model against hand-computed results.
    model_window(0, edge_win, gx, gy, mag);
    checkOutput("model_sobel_gx", gx, 1020);
    checkOutput("model_sobel_mag", mag, 255);
    model_window(1, top_win, gx, gy, mag);
    checkOutput("model_prewitt_gy", gy, 300);
    checkOutput("model_prewitt_mag", mag, 75);
    model_window(2, mirror_win, gx, gy, mag);
    checkOutput("model_scharr_gx", gx, -4080);
    model_window(0, ramp_win, gx, gy, mag);
    checkOutput("model_ramp_gy", gy, -240);

    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    $display("[TB] Sobel vertical edge");
    applyStimulus(0, 0, 99, edge_win, 9);
    waitResult("sobel", 1020, 0, 255);
    releaseResult();

    $display("[TB] Prewitt top row");
    applyStimulus(1, 1, 99, top_win, 9);
    waitResult("prewitt", 0, 300, 75);
    releaseResult();

    $display("[TB] Scharr edge and mirror");
    applyStimulus(2, 2, 99, edge_win, 9);
    waitResult("scharr", 4080, 0, 255);
    releaseResult();
    applyStimulus(2, 2, 99, mirror_win, 9);
    waitResult("scharr_mirror", -4080, 0, 255);
    releaseResult();

    $display("[TB] Backpressure with a waiting beat");
    applyStimulus(0, 0, 99, ramp_win, 9);
    waitResult("bp", 80, -240, 80);
    pix_valid_i = 1'b1;
    pix_i       = 8'd200;
    mode_i      = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_gx", gx_o, 80);
      checkOutput("bp_hold_ready", {31'b0, pix_ready_o}, 0);
    end
    releaseResult();
    applyStimulus(0, 0, 99, corner_win, 9);
    waitResult("bp_next", -200, 200, 100);
    releaseResult();

    $display("[TB] Flush mid-window, mode change mid-window");
    applyStimulus(0, 0, 99, full_win, 5);
    @(negedge clk);
    flush_i     = 1'b1;
    pix_valid_i = 1'b1;
    pix_i       = 8'd77;
    applyStimulus(0, 2, 3, ramp_win, 9);
    waitResult("flush", 80, -240, 80);

    $display("[TB] Flush in OUT");
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_out_valid", {31'b0, out_valid_o}, 0);

    $display("[TB] Reset mid-window and in OUT");
    applyStimulus(2, 2, 99, full_win, 4);
    pulseReset();
    applyStimulus(1, 1, 99, ramp_win, 9);
    waitResult("post_rst", 60, -180, 60);
    pulseReset();
    applyStimulus(3, 3, 99, ramp_win, 9);
    waitResult("reserved", 80, -240, 80);
    releaseResult();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
